// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and responder-state types plus alignment/lane helpers
package mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_WYDE, SZ_TETRA, SZ_OCTA} mem_size_t;
  typedef enum logic [2:0] {IDLE, RD1, RD2, WR2, RESP} resp_state_t;
  function automatic logic [63:0] align_addr(logic [63:0] addr, mem_size_t size);
    return addr & ~((64'd1 << size) - 64'd1);
  endfunction
  function automatic logic [3:0] lane_mask(logic [1:0] offset, mem_size_t size);
    return size == SZ_BYTE ? 4'b1000 >> offset :
           size == SZ_WYDE ? (offset[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_lane_steer.sv
// mem_lane_steer: big-endian lane placement of write data and extraction of read data
module mem_lane_steer
  import mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wpos,
  output logic [31:0] rext,
  output logic [3:0]  be
);
  assign wpos = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_WYDE ? {2{wdata[15:0]}} : wdata;
  assign rext = size == SZ_BYTE ? {24'b0, rdata[{~offset, 3'b000} +: 8]} :
                size == SZ_WYDE ? {16'b0, rdata[{~offset[1], 4'b0000} +: 16]} : rdata;
  assign be = lane_mask(offset, size);
endmodule

// File: rtl/mem_responder.sv
// mem_responder: services level-held memory requests against a 32-bit synchronous RAM
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           mem_address,
  input  logic [1:0]            mem_datasize,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [63:0]           mem_writedata,
  output logic [63:0]           mem_readdata,
  output logic                  mem_done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_writedata,
  output logic [3:0]            ram_byteenable,
  output logic                  ram_write,
  input  logic [31:0]           ram_readdata
);
  localparam int AW2 = ADDR_WIDTH + 2;
  resp_state_t state, state_nx;
  mem_size_t size_in, size_q, st_size;
  logic [63:0] aligned;
  logic [AW2-1:0] addr_q;
  logic [31:0] hi_q, st_wdata, wpos, rext;
  logic [3:0] be;
  logic [1:0] st_off;
  logic [ADDR_WIDTH-1:0] word_nx;
  logic idle, addr_unused;
  assign size_in = mem_size_t'(mem_datasize);
  assign aligned = align_addr(mem_address, size_in);
  assign addr_unused = ^{mem_address[63:AW2], aligned[63:AW2]};
  assign idle = state == IDLE;
  assign st_size = idle ? size_in : size_q;
  assign st_off = idle ? aligned[1:0] : addr_q[1:0];
  assign st_wdata = idle && size_in == SZ_OCTA ? mem_writedata[63:32] : mem_writedata[31:0];
  assign word_nx = addr_q[AW2-1:2] + ADDR_WIDTH'(1);
  mem_lane_steer u_steer (
    .size(st_size),
    .offset(st_off),
    .wdata(st_wdata),
    .rdata(ram_readdata),
    .wpos(wpos),
    .rext(rext),
    .be(be)
  );
  always_comb begin
    state_nx = state;
    mem_done = 1'b0;
    ram_write = 1'b0;
    ram_address = '0;
    ram_writedata = '0;
    ram_byteenable = '0;
    unique case (state)
      IDLE: begin
        if (mem_read) begin
          ram_address = aligned[AW2-1:2];
          state_nx = RD1;
        end else if (mem_write) begin
          ram_address = aligned[AW2-1:2];
          ram_write = 1'b1;
          ram_writedata = wpos;
          ram_byteenable = be;
          state_nx = size_in == SZ_OCTA ? WR2 : RESP;
        end
      end
      RD1: begin
        ram_address = size_q == SZ_OCTA ? word_nx : '0;
        state_nx = size_q == SZ_OCTA ? RD2 : RESP;
      end
      RD2: state_nx = RESP;
      WR2: begin
        ram_address = word_nx;
        ram_write = 1'b1;
        ram_writedata = wpos;
        ram_byteenable = be;
        state_nx = RESP;
      end
      RESP: begin
        mem_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      mem_done = 1'b0;
      ram_write = 1'b0;
      ram_address = '0;
      ram_writedata = '0;
      ram_byteenable = '0;
    end
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      size_q <= SZ_BYTE;
      hi_q <= '0;
      mem_readdata <= '0;
    end else begin
      if (idle) begin
        addr_q <= aligned[AW2-1:0];
        size_q <= size_in;
      end
      if (state == RD1 && size_q == SZ_OCTA) hi_q <= ram_readdata;
      if (state == RD1 && size_q != SZ_OCTA) mem_readdata <= {32'b0, rext};
      if (state == RD2) mem_readdata <= {hi_q, ram_readdata};
    end
  end
endmodule
